// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one single-beat memory port among NREQ cores, with watchdog
module mem_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 1023,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_access,
  input  logic [NREQ-1:0]   i_req_write,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_st_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [DW-1:0]     o_req_data,
  output logic [AW-1:0]     o_mem_a,
  output logic [DW-1:0]     o_mem_st_data,
  output logic              o_mem_access,
  output logic              o_mem_write,
  input  logic [DW-1:0]     i_mem_data,
  input  logic              i_mem_ready,
  output logic [GW-1:0]     o_grant_id,
  output logic              o_busy,
  output logic              o_timeout_err
);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last;
  logic [WW-1:0]   r_wdog;
  logic            r_timeout_err;
  logic            w_busy;
  logic            w_found;
  logic            w_fire;
  logic [GW-1:0]   w_next;

  assign w_busy        = (r_state == S_BUSY);
  assign w_fire        = (TIMEOUT != 0) && w_busy && !i_mem_ready && (r_wdog == TLAST);
  assign o_busy        = w_busy;
  assign o_grant_id    = r_grant;
  assign o_timeout_err = r_timeout_err;
  assign o_req_data    = i_mem_data;
  assign o_mem_access  = w_busy & i_req_access[r_grant];
  assign o_mem_write   = w_busy & i_req_write[r_grant];
  assign o_mem_a       = w_busy ? i_req_addr[r_grant*AW +: AW] : '0;
  assign o_mem_st_data = w_busy ? i_req_st_data[r_grant*DW +: DW] : '0;
  assign o_req_ready   = (w_busy & i_mem_ready) ? (NREQ'(1) << r_grant) : '0;

  // pick the first requester after the last served core, scanning downward so the nearest one wins
  always_comb begin
    w_found = 1'b0;
    w_next  = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req_access[(int'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_next  = GW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // IDLE/BUSY controller with grant, fairness pointer and saturating watchdog
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_last        <= GW'(NREQ - 1);
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_found) begin
        r_state <= S_BUSY;
        r_grant <= w_next;
        r_wdog  <= '0;
      end
    end else if (i_mem_ready) begin
      r_state <= S_IDLE;
      r_last  <= r_grant;
    end else if (w_fire) begin
      r_state       <= S_IDLE;
      r_last        <= r_grant;
      r_timeout_err <= 1'b1;
    end else if (r_wdog != '1) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed checks of arbitration order, muxing, watchdog and async reset
module tb_mem_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_access = '0;
  logic [3:0]   req_write = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_st_data = '0;
  logic [3:0]   req_ready;
  logic [31:0]  req_data;
  logic [31:0]  mem_a;
  logic [31:0]  mem_st_data;
  logic         mem_access;
  logic         mem_write;
  logic [31:0]  mem_data = '0;
  logic         mem_ready = 1'b0;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;
  int           n_tests = 0;
  int           n_fail = 0;
  int           exp_seq [5] = '{0, 1, 2, 3, 0};

  mem_rr_arbiter #(.NREQ(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_access(req_access), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_st_data(req_st_data),
    .o_req_ready(req_ready), .o_req_data(req_data),
    .o_mem_a(mem_a), .o_mem_st_data(mem_st_data),
    .o_mem_access(mem_access), .o_mem_write(mem_write),
    .i_mem_data(mem_data), .i_mem_ready(mem_ready),
    .o_grant_id(grant_id), .o_busy(busy), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    nxt();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_macc", mem_access, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_terr", timeout_err, 0);
    nxt();
    rst = 1'b0;

    // single load from core0, memory answers 3 cycles after mem_access
    nxt();
    req_access = 4'b0001;
    req_addr[31:0] = 32'h100;
    #1 chk("s1_idle_macc", mem_access, 0);
    nxt();
    #1;
    chk("s1_macc", mem_access, 1);
    chk("s1_addr", mem_a, 32'h100);
    chk("s1_write", mem_write, 0);
    chk("s1_grant", grant_id, 0);
    nxt();
    #1 chk("s1_wait_ready", req_ready, 0);
    nxt();
    #1 chk("s1_wait_ready2", req_ready, 0);
    nxt();
    mem_ready = 1'b1;
    mem_data = 32'hDEADBEEF;
    #1;
    chk("s1_ready", req_ready, 4'b0001);
    chk("s1_data", req_data, 32'hDEADBEEF);
    nxt();
    mem_ready = 1'b0;
    req_access = '0;
    #1;
    chk("s1_busy_fall", busy, 0);
    chk("s1_ready_fall", req_ready, 0);

    // fresh reset, then all four cores request continuously with 1-cycle memory
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    req_access = 4'b1111;
    #1 chk("s2_idle0", busy, 0);
    for (int i = 0; i < 5; i++) begin
      nxt();
      mem_ready = 1'b1;
      #1;
      chk($sformatf("s2_grant%0d", i), grant_id, exp_seq[i]);
      chk($sformatf("s2_ready%0d", i), req_ready, 4'b0001 << exp_seq[i]);
      nxt();
      mem_ready = 1'b0;
      #1 chk($sformatf("s2_gap%0d", i), busy, 0);
    end
    req_access = '0;

    // core2 store held while core1 arrives mid-transaction; core1 wins next
    nxt();
    req_access = 4'b0100;
    req_write = 4'b0100;
    req_addr[95:64] = 32'h40;
    req_st_data[95:64] = 32'h12345678;
    nxt();
    req_access = 4'b0110;
    #1;
    chk("s3_grant", grant_id, 2);
    chk("s3_write", mem_write, 1);
    chk("s3_stdata", mem_st_data, 32'h12345678);
    chk("s3_addr", mem_a, 32'h40);
    nxt();
    #1;
    chk("s3_hold_grant", grant_id, 2);
    chk("s3_hold_write", mem_write, 1);
    chk("s3_hold_stdata", mem_st_data, 32'h12345678);
    nxt();
    mem_ready = 1'b1;
    #1 chk("s3_ready2", req_ready, 4'b0100);
    nxt();
    mem_ready = 1'b0;
    req_access = 4'b0010;
    req_write = '0;
    #1;
    chk("s3_gap", busy, 0);
    chk("s3_idle_mwrite", mem_write, 0);
    nxt();
    #1;
    chk("s3_grant1", grant_id, 1);
    chk("s3_busy1", busy, 1);
    mem_ready = 1'b1;
    #1 chk("s3_ready1", req_ready, 4'b0010);
    nxt();
    mem_ready = 1'b0;
    req_access = '0;

    // watchdog: core3 never answered, fires after 8 BUSY cycles
    nxt();
    req_access = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      nxt();
      #1;
      chk($sformatf("s4_busy%0d", i), busy, 1);
      chk($sformatf("s4_terr%0d", i), timeout_err, 0);
    end
    nxt();
    req_access = 4'b1001;
    #1;
    chk("s4_idle", busy, 0);
    chk("s4_terr", timeout_err, 1);
    chk("s4_noready", req_ready, 0);
    nxt();
    #1;
    chk("s4_next_grant", grant_id, 0);
    chk("s4_next_busy", busy, 1);
    mem_ready = 1'b1;
    #1;
    chk("s4_next_ready", req_ready, 4'b0001);
    chk("s4_terr_sticky", timeout_err, 1);
    nxt();
    mem_ready = 1'b0;
    req_access = '0;

    // asynchronous reset in the middle of a BUSY cycle
    nxt();
    req_access = 4'b0010;
    nxt();
    #1;
    chk("s5_grant1", grant_id, 1);
    chk("s5_macc1", mem_access, 1);
    mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("s5_macc", mem_access, 0);
    chk("s5_busy", busy, 0);
    chk("s5_grant", grant_id, 0);
    chk("s5_ready", req_ready, 0);
    chk("s5_terr", timeout_err, 0);
    mem_ready = 1'b0;
    nxt();
    rst = 1'b0;
    req_access = 4'b0011;
    nxt();
    #1 chk("s5_first", grant_id, 0);
    mem_ready = 1'b1;
    nxt();
    mem_ready = 1'b0;
    req_access = '0;

    // spurious mem_ready in IDLE
    nxt();
    mem_ready = 1'b1;
    #1;
    chk("s6_ready", req_ready, 0);
    chk("s6_busy", busy, 0);
    nxt();
    #1;
    chk("s6_busy2", busy, 0);
    chk("s6_grant", grant_id, 0);
    mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Round-robin arbiter that shares one physical_memory port among NREQ cpu_cache_tlb cores in the multi-core build. Each core issues a single-beat load or store with a level access/ready handshake. The arbiter grants one core at a time and holds the grant until the memory returns mem_ready. It routes that core's request to memory and steers ready back to it. A watchdog flags a memory that never answers.

Parameters:
NREQ, 4, number of requesting cores (2..8); grant_id width is GW = clog2(NREQ), minimum 1
AW, 32, address width
DW, 32, data width
TIMEOUT, 1023, BUSY cycles without mem_ready before watchdog fires; 0 disables the watchdog

Ports:
clock  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
req_access  in  NREQ  per-core request; held high until that core's req_ready
req_write  in  NREQ  per-core store flag (1 = store), valid while req_access is high
req_addr  in  NREQ*AW  flattened per-core addresses; core i uses bits [i*AW +: AW]
req_st_data  in  NREQ*DW  flattened per-core store data
req_ready  out  NREQ  per-core completion strobe
req_data  out  DW  load data, broadcast to all cores and qualified by req_ready
mem_a  out  AW  memory address
mem_st_data  out  DW  memory store data
mem_access  out  1  memory request
mem_write  out  1  memory store flag
mem_data  in  DW  memory load data
mem_ready  in  1  memory completion, sampled at posedge
grant_id  out  GW  index of the granted core, or the last granted core when idle
busy  out  1  high in BUSY
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values (asynchronous): state=IDLE, grant_id=0, last pointer=NREQ-1 (core 0 wins first), wdog=0, timeout_err=0.
- Combinational outputs under reset: mem_access=0, mem_write=0, mem_a=0, mem_st_data=0, req_ready=0, busy=0.
- Two-state FSM: IDLE and BUSY.
- IDLE, any req_access bit set:
  - Select the first set bit scanning last+1, last+2, ... modulo NREQ.
  - At the next posedge: load grant_id, go to BUSY, clear wdog.
  - With no requests, remain in IDLE.
- BUSY, memory-side outputs:
  - mem_access = req_access[grant_id]; mem_write, mem_a, mem_st_data are muxed combinationally from core grant_id.
  - Latency from request to mem_access is exactly 1 cycle.
- IDLE, memory-side outputs: all zero.
- req_ready[i] = mem_ready & busy & (grant_id==i), combinational; all other bits stay 0.
- req_data = mem_data, unconditional passthrough.
- BUSY with mem_ready=1 at a posedge: set last=grant_id, go to IDLE.
  - A mandatory single IDLE cycle separates transactions, so the served core can drop req_access before re-arbitration.
  - Peak throughput is one transaction per 2 + memory-latency cycles.
- Fairness: the just-served core has lowest priority in the next arbitration, so each pending core is granted within NREQ transactions.
- Requests that arrive or change while another core is in BUSY do not affect the current grant.
- A granted core dropping req_access without ready is a protocol violation. The arbiter still stays in BUSY until mem_ready or the watchdog fires; mem_access follows the dropped request and goes low.
- mem_ready while in IDLE is ignored and does not change state.
- Watchdog, when TIMEOUT != 0:
  - wdog increments every BUSY cycle with mem_ready=0.
  - When wdog==TIMEOUT-1 and mem_ready=0: set timeout_err=1, set last=grant_id, return to IDLE, drive no req_ready.
  - timeout_err clears only on reset.
  - The wdog counter saturates and never wraps.
- Reset asserted mid-transaction: immediately return to IDLE. mem_access drops asynchronously and no req_ready is generated.

Test Plan:
- Reset, then core0 only: addr 0x100, load; memory answers mem_ready 3 cycles after mem_access with mem_data=0xDEADBEEF -> mem_access rises 1 cycle after req_access, mem_a=0x100, req_ready=4'b0001 for 1 cycle with req_data=0xDEADBEEF, busy falls at the next posedge.
- All four cores request continuously with 1-cycle memory -> grant_id sequence 0,1,2,3,0; each transaction is separated by one IDLE cycle; no core is granted twice before the others.
- Core2 stores 0x12345678 to 0x40 while core1 raises a request mid-transaction -> mem_write=1 and mem_st_data=0x12345678 are held until ready; core1 is granted next.
- Memory never asserts ready with TIMEOUT=8 -> after 8 BUSY cycles timeout_err=1, FSM returns to IDLE, req_ready stays 0, next requester is granted normally, timeout_err stays high.
- Reset asserted during BUSY -> mem_access, busy and grant_id go to 0 without waiting for a clock edge; after release, core0 has first priority.
- Spurious mem_ready pulse in IDLE -> no req_ready, FSM state unchanged.
